// File: rtl/multi_port_reg_file.sv
// ============================================================================
// multi_port_reg_file
//   Parametrised register file for the processor datapath: NUM_RD
//   combinational read ports and NUM_WR synchronous write ports. A built-in
//   clear sequencer zeroes every entry after reset or on request; `ready`
//   stays low for the whole sweep and gates the start of the pipeline.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   : a read of an index being written in the same cycle returns
//               the write data (highest-numbered matching write port).
//   undefined : pure storage read; written data is visible the next cycle.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst       in   synchronous active-high reset (restarts the clear sweep)
//   clearReq  in   start a clear sweep (honoured only while ready=1)
//   ready     out  1 = file valid, writes accepted
//   rdNum     in   NUM_RD x REG_NUM_WIDTH read indices
//   rdData    out  NUM_RD x DATA_WIDTH read data (combinational)
//   wrEnable  in   NUM_WR per-port write enables
//   wrNum     in   NUM_WR x REG_NUM_WIDTH write indices
//   wrData    in   NUM_WR x DATA_WIDTH write data
// ============================================================================
module multi_port_reg_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM       = 32,
    parameter int REG_NUM_WIDTH = $clog2(REG_NUM),
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2,
    parameter int ZERO_REG      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clearReq,
    output logic                                  ready,
    input  logic [NUM_RD-1:0][REG_NUM_WIDTH-1:0]  rdNum,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rdData,
    input  logic [NUM_WR-1:0]                     wrEnable,
    input  logic [NUM_WR-1:0][REG_NUM_WIDTH-1:0]  wrNum,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wrData
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int IDX_SPACE = 1 << REG_NUM_WIDTH;

    // One bit per encodable index: set where the index maps to a real entry.
    // Lets the read path reject out-of-range indices without a magnitude
    // compare when REG_NUM is not a power of two.
    localparam logic [IDX_SPACE-1:0] IDX_VALID =
        {IDX_SPACE{1'b1}} >> (IDX_SPACE - REG_NUM);

    state_t                   state_reg;
    logic [REG_NUM_WIDTH-1:0] clr_idx_reg;
    logic [DATA_WIDTH-1:0]    entry_q [REG_NUM];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_idx_reg <= clr_idx_reg + 1'b1;
                    if (clr_idx_reg == REG_NUM_WIDTH'(REG_NUM - 1)) begin
                        state_reg <= READY;
                    end
                end
                READY: begin
                    if (clearReq) begin
                        state_reg   <= CLEAR;
                        clr_idx_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= CLEAR;
                    clr_idx_reg <= '0;
                end
            endcase
        end
    end

    // ready is the state register bit itself, so it is glitch-free.
    assign ready = (state_reg == READY);

    // ------------------------------------------------------------------
    // Storage: one register per entry with its own write decode
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  wr_hit;
            logic [DATA_WIDTH-1:0] wr_val;

            // Ascending scan: the last matching port overrides earlier ones,
            // so the highest-numbered port wins a same-index conflict.
            always_comb begin
                wr_hit = 1'b0;
                wr_val = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wrEnable[p] && (wrNum[p] == REG_NUM_WIDTH'(gi))) begin
                        wr_hit = 1'b1;
                        wr_val = wrData[p];
                    end
                end
                if ((ZERO_REG != 0) && (gi == 0)) begin
                    wr_hit = 1'b0;
                end
            end

            // No reset branch: the clear sweep is what zeroes the contents.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (state_reg == CLEAR) begin
                        if (clr_idx_reg == REG_NUM_WIDTH'(gi)) begin
                            value_reg <= '0;
                        end
                    end else if (wr_hit) begin
                        value_reg <= wr_val;
                    end
                end
            end

            assign entry_q[gi] = value_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports (combinational)
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [REG_NUM_WIDTH-1:0] rd_idx;
            logic                     rd_allowed;

            assign rd_idx = rdNum[gi];

            always_comb begin
                rd_allowed = (state_reg == READY) && IDX_VALID[rd_idx];
                if ((ZERO_REG != 0) && (rd_idx == '0)) begin
                    rd_allowed = 1'b0;
                end
            end

            always_comb begin
                rdData[gi] = '0;
                if (rd_allowed) begin
                    rdData[gi] = entry_q[rd_idx];
`ifdef REG_FILE_BYPASS_EN
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wrEnable[p] && (wrNum[p] == rd_idx)) begin
                            rdData[gi] = wrData[p];
                        end
                    end
`endif
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_multi_port_reg_file.sv
// ============================================================================
// tb_multi_port_reg_file
//   Two instances share all inputs: one with the hardwired zero register and
//   one without. A behavioural model (plain arrays and a remaining-clear
//   cycle count) predicts ready and every read port; a negedge process
//   compares both instances every cycle, and directed steps add literal
//   expectations for the documented scenarios.
// ============================================================================
module tb_multi_port_reg_file;

    localparam int DW = 32;
    localparam int RN = 32;
    localparam int RW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear_req;
    logic [1:0][RW-1:0]     rd_num;
    logic [1:0]             wr_en;
    logic [1:0][RW-1:0]     wr_num;
    logic [1:0][DW-1:0]     wr_data;

    logic                   rdy_z, rdy_n;
    logic [1:0][DW-1:0]     rd_data_z, rd_data_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_port_reg_file #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .clearReq(clear_req), .ready(rdy_z),
        .rdNum(rd_num), .rdData(rd_data_z),
        .wrEnable(wr_en), .wrNum(wr_num), .wrData(wr_data)
    );

    multi_port_reg_file #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst), .clearReq(clear_req), .ready(rdy_n),
        .rdNum(rd_num), .rdData(rd_data_n),
        .wrEnable(wr_en), .wrNum(wr_num), .wrData(wr_data)
    );

    // ---------------- model ----------------
    // m_mem[0] mirrors the ZERO_REG=1 instance, m_mem[1] the ZERO_REG=0 one.
    // Contents are zeroed at once when a clear starts: reads are forced to 0
    // during the sweep and writes are dropped, so this is indistinguishable.
    logic [DW-1:0] m_mem [2][RN];
    int            m_left  = RN;
    bit            m_valid = 1'b0;

    task automatic model_wipe();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < RN; r++) m_mem[k][r] = '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_left  = RN;
            model_wipe();
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    m_mem[1][wr_num[p]] = wr_data[p];
                    if (wr_num[p] != 0) m_mem[0][wr_num[p]] = wr_data[p];
                end
            end
            if (clear_req) begin
                m_left = RN;
                model_wipe();
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(int inst, logic [RW-1:0] idx);
        logic [DW-1:0] v;
        if (m_left != 0) return '0;
        if (inst == 0 && idx == 0) return '0;
        v = m_mem[inst][idx];
`ifdef REG_FILE_BYPASS_EN
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_num[p] == idx) v = wr_data[p];
`endif
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready_z", {31'd0, rdy_z}, {31'd0, m_left == 0});
            check("ready_n", {31'd0, rdy_n}, {31'd0, m_left == 0});
            for (int j = 0; j < 2; j++) begin
                check($sformatf("rd_z[%0d] idx %0d", j, rd_num[j]), rd_data_z[j], exp_rd(0, rd_num[j]));
                check($sformatf("rd_n[%0d] idx %0d", j, rd_num[j]), rd_data_n[j], exp_rd(1, rd_num[j]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!rdy_z && n < 100) begin
            step();
            n++;
        end
        check(name, n, 32);
        $display("[TB] %s: ready after %0d cycles", name, n);
    endtask

    task automatic write1(int port, int idx, logic [DW-1:0] val);
        wr_en         = '0;
        wr_en[port]   = 1'b1;
        wr_num[port]  = RW'(idx);
        wr_data[port] = val;
    endtask

    initial begin
        rst = 1'b1; clear_req = 1'b0; rd_num = '0;
        wr_en = '0; wr_num = '0; wr_data = '0;
        step();
        rst = 1'b0;

        // 1: reset then idle
        check("ready_low_after_rst", {31'd0, rdy_z}, 32'd0);
        wait_ready("reset_sweep");
        for (int r = 0; r < RN; r++) begin
            rd_num[0] = RW'(r);
            rd_num[1] = RW'(RN - 1 - r);
            #1;
            check("post_reset_zero_p0", rd_data_n[0], 32'd0);
            check("post_reset_zero_p1", rd_data_n[1], 32'd0);
            step();
        end
        $display("[TB] reset readback done");

        // 2: port conflict, highest port wins
        wr_en = 2'b11; wr_num[0] = 5; wr_num[1] = 5;
        wr_data[0] = 32'hAAAA; wr_data[1] = 32'hBBBB;
        rd_num[1] = 5;
        step();
        wr_en = '0; rd_num[0] = 5;
        #1;
        check("conflict_reg5", rd_data_z[0], 32'hBBBB);
        $display("[TB] conflict write reg5 -> 0x%h", rd_data_z[0]);

        // 3: zero register
        write1(1, 0, 32'h1234);
        step();
        wr_en = '0; rd_num[0] = 0;
        #1;
        check("zero_reg_hard", rd_data_z[0], 32'd0);
        check("zero_reg_soft", rd_data_n[0], 32'h1234);
        $display("[TB] reg0 write: zr=0x%h nz=0x%h", rd_data_z[0], rd_data_n[0]);

        // 4: same-cycle read of a written index
        write1(0, 7, 32'h1111);
        step();
        write1(1, 7, 32'hDEAD);
        rd_num[1] = 7;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass_reg7", rd_data_z[1], 32'hDEAD);
`else
        check("nobypass_reg7", rd_data_z[1], 32'h1111);
`endif
        $display("[TB] same-cycle read reg7 -> 0x%h", rd_data_z[1]);
        step();
        wr_en = '0;
        #1;
        check("reg7_next_cycle", rd_data_z[1], 32'hDEAD);

        // bulk writes on alternating ports, reads trail by one index
        for (int r = 1; r < RN; r++) begin
            write1(r % 2, r, (32'h01010101 * r) ^ 32'hA5A5A5A5);
            rd_num[0] = RW'(r - 1);
            rd_num[1] = RW'(r);
            step();
        end
        wr_en = '0;
        rd_num[0] = 10;
        #1;
        check("bulk_reg10", rd_data_z[0], 32'h0A0A0A0A ^ 32'hA5A5A5A5);
        $display("[TB] bulk fill done");

        // 5: clear request
        write1(0, 3, 32'h55);
        step();
        write1(0, 9, 32'h77);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        write1(0, 3, 32'h99);
        check("ready_low_in_clear", {31'd0, rdy_z}, 32'd0);
        wait_ready("clear_sweep");
        wr_en = '0;
        rd_num[0] = 3; rd_num[1] = 9;
        #1;
        check("reg3_cleared", rd_data_z[0], 32'd0);
        check("reg9_cleared", rd_data_z[1], 32'd0);
        $display("[TB] after clearReq reg3=0x%h reg9=0x%h", rd_data_z[0], rd_data_z[1]);
        step();

        // 6: reset mid-sweep
        write1(1, 12, 32'hCAFE);
        step();
        wr_en = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("ready_low_mid_sweep", {31'd0, rdy_z}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("restart_sweep");
        rd_num[0] = 12; rd_num[1] = 5;
        #1;
        check("reg12_after_restart", rd_data_n[0], 32'd0);
        check("reg5_after_restart", rd_data_n[1], 32'd0);
        $display("[TB] after restart reg12=0x%h reg5=0x%h", rd_data_n[0], rd_data_n[1]);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
